// File: rtl/div_hilo_ctrl_if.sv
// rtl/div_hilo_ctrl_if.sv - handshake bundle between the HI/LO sequencer and the iterative divider
//
// Purpose: carries the start pulse and operands to the divider and the
// completion pulse, zero flag and results back from it.
// Signals:
//   DivStart  one-cycle start pulse to divider
//   DivA      dividend to divider (32)
//   DivB      divisor to divider (32)
//   DivDone   divider completion pulse, results valid same cycle
//   DivZero   divider divide-by-zero flag, qualified by DivDone
//   DivHigh   divider remainder (32)
//   DivLow    divider quotient (32)
// Modports: master = sequencer side, slave = divider side.

interface div_hilo_ctrl_if;
  logic        DivStart;
  logic [31:0] DivA;
  logic [31:0] DivB;
  logic        DivDone;
  logic        DivZero;
  logic [31:0] DivHigh;
  logic [31:0] DivLow;

  modport master (
    output DivStart, DivA, DivB,
    input  DivDone, DivZero, DivHigh, DivLow
  );

  modport slave (
    input  DivStart, DivA, DivB,
    output DivDone, DivZero, DivHigh, DivLow
  );
endinterface

// File: rtl/div_hilo_ctrl.sv
// rtl/div_hilo_ctrl.sv - DIV sequencer and HI/LO register owner
//
// Purpose: latches DIV operands, pulses the divider start, waits for the
// divider to finish and writes remainder/quotient into HI/LO. Flags
// divide-by-zero and divider timeout, and holds Busy while a division is
// in flight so the control unit stalls MFHI/MFLO/DIV.
// Optional feature: define DIV_SIGNED_EN for signed DIV support (operand
// magnitudes go to the divider, a FIX state restores result signs).
// Ports:
//   clk         system clock, posedge
//   Reset       synchronous active-high reset
//   DivReq      DIV issue request (sampled only when idle)
//   DivSigned   1=DIV, 0=DIVU (used only with DIV_SIGNED_EN)
//   RsData      dividend (32)
//   RtData      divisor (32)
//   MtHi/MtLo   HI/LO write strobes
//   MtData      HI/LO write data (32)
//   div         divider handshake (master side)
//   Hi/Lo       HI/LO registers (32)
//   Busy        high whenever the sequencer is not idle
//   DivExc      one-cycle divide-by-zero exception pulse
//   DivTimeout  one-cycle divider timeout pulse

module div_hilo_ctrl #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   DivReq,
  input  logic                   DivSigned,
  input  logic [31:0]            RsData,
  input  logic [31:0]            RtData,
  input  logic                   MtHi,
  input  logic                   MtLo,
  input  logic [31:0]            MtData,
  div_hilo_ctrl_if.master        div,
  output logic [31:0]            Hi,
  output logic [31:0]            Lo,
  output logic                   Busy,
  output logic                   DivExc,
  output logic                   DivTimeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

`ifdef DIV_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_FIX} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_d, lo_d, diva_d, divb_d;
  logic          start_d, exc_d, tmo_d;

`ifdef DIV_SIGNED_EN
  // Operation sign bookkeeping for the FIX step.
  logic sop_q, sop_d;
  logic sgn_a_q, sgn_a_d;
  logic sgn_b_q, sgn_b_d;
`else
  logic unused_div_signed;
  assign unused_div_signed = DivSigned;
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      Hi           <= '0;
      Lo           <= '0;
      div.DivA     <= '0;
      div.DivB     <= '0;
      div.DivStart <= 1'b0;
      DivExc       <= 1'b0;
      DivTimeout   <= 1'b0;
      Busy         <= 1'b0;
`ifdef DIV_SIGNED_EN
      sop_q        <= 1'b0;
      sgn_a_q      <= 1'b0;
      sgn_b_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      Hi           <= hi_d;
      Lo           <= lo_d;
      div.DivA     <= diva_d;
      div.DivB     <= divb_d;
      div.DivStart <= start_d;
      DivExc       <= exc_d;
      DivTimeout   <= tmo_d;
      // Registered from the next state so Busy lines up with state_q.
      Busy         <= (state_d != S_IDLE);
`ifdef DIV_SIGNED_EN
      sop_q        <= sop_d;
      sgn_a_q      <= sgn_a_d;
      sgn_b_q      <= sgn_b_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = Hi;
    lo_d    = Lo;
    diva_d  = div.DivA;
    divb_d  = div.DivB;
    start_d = 1'b0;
    exc_d   = 1'b0;
    tmo_d   = 1'b0;
`ifdef DIV_SIGNED_EN
    sop_d   = sop_q;
    sgn_a_d = sgn_a_q;
    sgn_b_d = sgn_b_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // MT writes land even alongside a DivReq; the DIV result later
        // overwrites them.
        if (MtHi) hi_d = MtData;
        if (MtLo) lo_d = MtData;
        if (DivReq) begin
          if (RtData == 32'd0) begin
            exc_d = 1'b1;
          end else begin
`ifdef DIV_SIGNED_EN
            sop_d   = DivSigned;
            sgn_a_d = DivSigned & RsData[31];
            sgn_b_d = DivSigned & RtData[31];
            diva_d  = (DivSigned && RsData[31]) ? (~RsData + 32'd1) : RsData;
            divb_d  = (DivSigned && RtData[31]) ? (~RtData + 32'd1) : RtData;
`else
            diva_d  = RsData;
            divb_d  = RtData;
`endif
            start_d = 1'b1;
            state_d = S_START;
          end
        end
      end

      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // Completion is checked first so a DivDone on the final allowed
        // cycle beats the timeout.
        if (div.DivDone) begin
          state_d = S_IDLE;
          if (div.DivZero) begin
            exc_d = 1'b1;
          end else begin
            hi_d = div.DivHigh;
            lo_d = div.DivLow;
`ifdef DIV_SIGNED_EN
            if (sop_q) state_d = S_FIX;
`endif
          end
        end else if (cnt_q == CNT_LAST) begin
          // This is the TIMEOUT_CYCLES-th cycle spent waiting.
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

`ifdef DIV_SIGNED_EN
      S_FIX: begin
        // Quotient is negative when operand signs differ; remainder
        // follows the dividend. 0x80000000/-1 falls out naturally as
        // -(0x80000000) == 0x80000000 with remainder 0.
        if (sgn_a_q ^ sgn_b_q) lo_d = ~Lo + 32'd1;
        if (sgn_a_q)           hi_d = ~Hi + 32'd1;
        state_d = S_IDLE;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb/tb_div_hilo_ctrl.sv - directed self-checking bench for div_hilo_ctrl

module tb_div_hilo_ctrl;

  logic        clk = 1'b0;
  logic        Reset;
  logic        DivReq, DivSigned, MtHi, MtLo;
  logic [31:0] RsData, RtData, MtData;
  logic [31:0] Hi, Lo;
  logic        Busy, DivExc, DivTimeout;

  int errors = 0;
  int checks = 0;

  div_hilo_ctrl_if dif();

  div_hilo_ctrl #(.TIMEOUT_CYCLES(40)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .DivReq     (DivReq),
    .DivSigned  (DivSigned),
    .RsData     (RsData),
    .RtData     (RtData),
    .MtHi       (MtHi),
    .MtLo       (MtLo),
    .MtData     (MtData),
    .div        (dif.master),
    .Hi         (Hi),
    .Lo         (Lo),
    .Busy       (Busy),
    .DivExc     (DivExc),
    .DivTimeout (DivTimeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Divider model plus request driver. Request is driven in cycle -1; the
  // divider reports done n edges after the edge that samples DivStart
  // (n<0: never). mt_cycle: -1 = MT strobes with the request, >=0 = MT
  // strobes in that busy cycle, -2 = none.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic zero,
                        input logic [31:0] rem, input logic [31:0] quo,
                        input int mt_cycle, input logic [31:0] mt_data,
                        output int busy_n, output int start_n,
                        output int exc_n, output int tmo_n);
    busy_n = 0; start_n = 0; exc_n = 0; tmo_n = 0;
    DivReq = 1'b1; DivSigned = sgn; RsData = a; RtData = b;
    MtHi = (mt_cycle == -1); MtLo = (mt_cycle == -1); MtData = mt_data;
    @(posedge clk); #1;
    DivReq = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
    for (int c = 0; c < 200; c++) begin
      dif.DivDone = 1'b0;
      MtHi = 1'b0; MtLo = 1'b0;
      if (dif.DivStart) start_n++;
      if (DivExc) exc_n++;
      if (DivTimeout) tmo_n++;
      if (!Busy) break;
      busy_n++;
      dif.DivDone = (n >= 0) && (c == n + 1);
      dif.DivZero = zero; dif.DivHigh = rem; dif.DivLow = quo;
      if (c == mt_cycle) begin MtHi = 1'b1; MtLo = 1'b1; MtData = mt_data; end
      @(posedge clk); #1;
    end
    dif.DivDone = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
    MtHi = h; MtLo = l; MtData = d;
    @(posedge clk); #1;
    MtHi = 1'b0; MtLo = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    checks++; if ({Hi, Lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h_%h exp 0_0", Hi, Lo); end
    checks++; if ({dif.DivA, dif.DivB} !== 64'd0) begin errors++; $display("FAIL reset_ab: got %h_%h exp 0_0", dif.DivA, dif.DivB); end
    checks++; if ({Busy, dif.DivStart, DivExc, DivTimeout} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {Busy, dif.DivStart, DivExc, DivTimeout}); end
  endtask

  task automatic test_divu_latency;
    int b, s, e, t;
    do_div(1'b0, 32'd100, 32'd7, 32, 1'b0, 32'd2, 32'd14, -2, 32'd0, b, s, e, t);
    checks++; if (s !== 1) begin errors++; $display("FAIL divu_start_pulses: got %0d exp 1", s); end
    checks++; if (b !== 34) begin errors++; $display("FAIL divu_busy_cycles: got %0d exp 34", b); end
    checks++; if (Hi !== 32'd2 || Lo !== 32'd14) begin errors++; $display("FAIL divu_result: got hi=%h lo=%h exp hi=2 lo=e", Hi, Lo); end
    checks++; if (dif.DivA !== 32'd100 || dif.DivB !== 32'd7) begin errors++; $display("FAIL divu_operands: got %h/%h exp 64/7", dif.DivA, dif.DivB); end
    checks++; if (e !== 0 || t !== 0) begin errors++; $display("FAIL divu_no_exc: got exc=%0d tmo=%0d exp 0 0", e, t); end
  endtask

  task automatic test_req_zero_divisor;
    int b, s, e, t;
    mt_write(1'b1, 1'b1, 32'h1111_2222);
    do_div(1'b0, 32'd55, 32'd0, 3, 1'b0, 32'd9, 32'd9, -2, 32'd0, b, s, e, t);
    checks++; if (e !== 1) begin errors++; $display("FAIL zreq_exc: got %0d exp 1", e); end
    checks++; if (s !== 0 || b !== 0) begin errors++; $display("FAIL zreq_idle: got start=%0d busy=%0d exp 0 0", s, b); end
    checks++; if (Hi !== 32'h1111_2222 || Lo !== 32'h1111_2222) begin errors++; $display("FAIL zreq_hilo: got %h/%h exp 11112222", Hi, Lo); end
  endtask

  task automatic test_timeout;
    int b, s, e, t;
    do_div(1'b0, 32'd9, 32'd3, -1, 1'b0, 32'd0, 32'd3, -2, 32'd0, b, s, e, t);
    checks++; if (t !== 1) begin errors++; $display("FAIL tmo_pulse: got %0d exp 1", t); end
    checks++; if (b !== 41) begin errors++; $display("FAIL tmo_busy_cycles: got %0d exp 41", b); end
    checks++; if (Hi !== 32'h1111_2222 || Lo !== 32'h1111_2222) begin errors++; $display("FAIL tmo_hilo: got %h/%h exp 11112222", Hi, Lo); end
  endtask

  task automatic test_done_at_timeout;
    int b, s, e, t;
    do_div(1'b0, 32'd9, 32'd4, 39, 1'b0, 32'd1, 32'd2, -2, 32'd0, b, s, e, t);
    checks++; if (t !== 0) begin errors++; $display("FAIL edge_tmo: got %0d exp 0", t); end
    checks++; if (Hi !== 32'd1 || Lo !== 32'd2 || b !== 41) begin errors++; $display("FAIL edge_result: got hi=%h lo=%h busy=%0d exp 1 2 41", Hi, Lo, b); end
  endtask

  task automatic test_divider_zero;
    int b, s, e, t;
    do_div(1'b0, 32'd8, 32'd2, 5, 1'b1, 32'd7, 32'd7, -2, 32'd0, b, s, e, t);
    checks++; if (e !== 1 || b !== 7) begin errors++; $display("FAIL dz_exc: got exc=%0d busy=%0d exp 1 7", e, b); end
    checks++; if (Hi !== 32'd1 || Lo !== 32'd2) begin errors++; $display("FAIL dz_hilo: got %h/%h exp 1/2", Hi, Lo); end
  endtask

  task automatic test_mt_write;
    mt_write(1'b1, 1'b1, 32'hDEAD_BEEF);
    checks++; if (Hi !== 32'hDEAD_BEEF || Lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mt_both: got %h/%h exp deadbeef", Hi, Lo); end
    mt_write(1'b1, 1'b0, 32'h0000_00A5);
    checks++; if (Hi !== 32'h0000_00A5 || Lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mt_hi_only: got %h/%h exp a5/deadbeef", Hi, Lo); end
  endtask

  task automatic test_mt_while_busy;
    int b, s, e, t;
    mt_write(1'b1, 1'b1, 32'hDEAD_BEEF);
    do_div(1'b0, 32'd8, 32'd2, 6, 1'b1, 32'd0, 32'd4, 3, 32'h5555_AAAA, b, s, e, t);
    checks++; if (Hi !== 32'hDEAD_BEEF || Lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mt_busy_ignored: got %h/%h exp deadbeef", Hi, Lo); end
  endtask

  task automatic test_mt_with_req;
    int b, s, e, t;
    do_div(1'b0, 32'd8, 32'd2, 4, 1'b1, 32'd0, 32'd4, -1, 32'h0BAD_F00D, b, s, e, t);
    checks++; if (Hi !== 32'h0BAD_F00D || Lo !== 32'h0BAD_F00D) begin errors++; $display("FAIL mt_req_write: got %h/%h exp 0badf00d", Hi, Lo); end
    do_div(1'b0, 32'd8, 32'd2, 4, 1'b0, 32'd0, 32'd4, -1, 32'h0BAD_F00D, b, s, e, t);
    checks++; if (Hi !== 32'd0 || Lo !== 32'd4) begin errors++; $display("FAIL mt_req_overwrite: got %h/%h exp 0/4", Hi, Lo); end
  endtask

  task automatic test_back_to_back;
    int b, s, e, t;
    do_div(1'b0, 32'd100, 32'd7, 2, 1'b0, 32'd2, 32'd14, -2, 32'd0, b, s, e, t);
    do_div(1'b0, 32'd1000, 32'd10, 3, 1'b0, 32'd0, 32'd100, -2, 32'd0, b, s, e, t);
    checks++; if (Hi !== 32'd0 || Lo !== 32'd100 || b !== 5 || s !== 1) begin errors++; $display("FAIL b2b_second: got hi=%h lo=%h busy=%0d start=%0d exp 0 64 5 1", Hi, Lo, b, s); end
  endtask

  task automatic test_reset_mid_wait;
    mt_write(1'b1, 1'b1, 32'h1234_5678);
    DivReq = 1'b1; DivSigned = 1'b0; RsData = 32'd100; RtData = 32'd7;
    @(posedge clk); #1 DivReq = 1'b0;
    repeat (5) @(posedge clk);
    #1 Reset = 1'b1;
    @(posedge clk); #1 Reset = 1'b0;
    @(posedge clk); #1;
    dif.DivDone = 1'b1; dif.DivZero = 1'b0; dif.DivHigh = 32'd2; dif.DivLow = 32'd14;
    @(posedge clk); #1 dif.DivDone = 1'b0;
    @(posedge clk); #1;
    checks++; if (Hi !== 32'd0 || Lo !== 32'd0) begin errors++; $display("FAIL rst_mid_hilo: got %h/%h exp 0/0", Hi, Lo); end
    checks++; if (Busy !== 1'b0 || dif.DivStart !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got busy=%b start=%b exp 0 0", Busy, dif.DivStart); end
  endtask

  task automatic test_signed;
    int b, s, e, t;
`ifdef DIV_SIGNED_EN
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 4, 1'b0, 32'd1, 32'd3, -2, 32'd0, b, s, e, t);
    checks++; if (dif.DivA !== 32'd7 || dif.DivB !== 32'd2) begin errors++; $display("FAIL sdiv_operands: got %h/%h exp 7/2", dif.DivA, dif.DivB); end
    checks++; if (Lo !== 32'hFFFF_FFFD || Hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_result: got hi=%h lo=%h exp ffffffff fffffffd", Hi, Lo); end
    checks++; if (b !== 7) begin errors++; $display("FAIL sdiv_busy: got %0d exp 7", b); end
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4, 1'b0, 32'd0, 32'h8000_0000, -2, 32'd0, b, s, e, t);
    checks++; if (Lo !== 32'h8000_0000 || Hi !== 32'd0) begin errors++; $display("FAIL sdiv_minint: got hi=%h lo=%h exp 0 80000000", Hi, Lo); end
`else
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 4, 1'b0, 32'd1, 32'h7FFF_FFFC, -2, 32'd0, b, s, e, t);
    checks++; if (dif.DivA !== 32'hFFFF_FFF9 || dif.DivB !== 32'd2) begin errors++; $display("FAIL usign_operands: got %h/%h exp fffffff9/2", dif.DivA, dif.DivB); end
    checks++; if (Lo !== 32'h7FFF_FFFC || Hi !== 32'd1 || b !== 6) begin errors++; $display("FAIL usign_result: got hi=%h lo=%h busy=%0d exp 1 7ffffffc 6", Hi, Lo, b); end
`endif
  endtask

  initial begin
    Reset = 1'b1; DivReq = 1'b0; DivSigned = 1'b0; RsData = '0; RtData = '0;
    MtHi = 1'b0; MtLo = 1'b0; MtData = '0;
    dif.DivDone = 1'b0; dif.DivZero = 1'b0; dif.DivHigh = '0; dif.DivLow = '0;
    test_reset();
    test_divu_latency();
    test_req_zero_divisor();
    test_timeout();
    test_done_at_timeout();
    test_divider_zero();
    test_mt_write();
    test_mt_while_busy();
    test_mt_with_req();
    test_back_to_back();
    test_signed();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
